lcd_read_controller: RTL and testbench

- Read-side companion to the write-only HD44780 character LCD controller.
- Drives LCD_RW high and generates EN pulses to read either the busy flag and address counter (RS=0) or a DDRAM/CGRAM data byte (RS=1).
- Optional mode polls the busy flag until it clears, with a timeout.
- Sits beside the writer; the top level uses oBusOwn to release the writer's data drivers and tristate the shared LCD data bus.

---
 rtl/lcd_pkg.sv | 23 ++
 rtl/lcd_read_controller_if.sv | 24 ++
 rtl/lcd_phase_timer.sv | 24 ++
 rtl/lcd_read_controller.sv | 159 +++++++++++++++
 tb/tb_lcd_read_controller.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 reader and writer: FSM states, RS encodings,
// busy-flag position and default timing.
package lcd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      EN_HI,
      EN_LO,
      DONE
   } lcd_state_t;

   localparam logic LCD_RS_INSTR = 1'b0;
   localparam logic LCD_RS_DATA  = 1'b1;
   localparam int   LCD_BF_BIT   = 7;

   localparam int LCD_SETUP_CLKS   = 2;
   localparam int LCD_EN_HIGH_CLKS = 16;
   localparam int LCD_EN_LOW_CLKS  = 16;
   localparam int LCD_POLL_MAX     = 1023;
   localparam int LCD_TMR_W        = 16;

endpackage

// File: rtl/lcd_read_controller_if.sv
// Request/response and LCD pin bundle for the read controller; slave is the controller side.
interface lcd_read_controller_if;
   logic       iStart;
   logic       iRS;
   logic       iPoll;
   logic [7:0] oDATA;
   logic       oDone;
   logic       oTimeout;
   logic       oBusOwn;
   logic [7:0] LCD_DATA_IN;
   logic       LCD_RW;
   logic       LCD_RS;
   logic       LCD_EN;

   modport master (
      output iStart, iRS, iPoll, LCD_DATA_IN,
      input  oDATA, oDone, oTimeout, oBusOwn, LCD_RW, LCD_RS, LCD_EN
   );

   modport slave (
      input  iStart, iRS, iPoll, LCD_DATA_IN,
      output oDATA, oDone, oTimeout, oBusOwn, LCD_RW, LCD_RS, LCD_EN
   );
endinterface

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
// Loading N-1 on phase entry makes the phase last N cycles.
module lcd_phase_timer #(
   parameter int W = 16
) (
   input  logic         iCLK,
   input  logic         iRST,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tc
);
   logic [W-1:0] cnt;

   always_ff @(posedge iCLK) begin
      if (iRST)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign tc = (cnt == '0);
endmodule

// File: rtl/lcd_read_controller.sv
// HD44780 read controller: busy-flag/address or data reads with optional BF polling.
// Define LCD_4BIT_EN to read each byte as two nibbles on LCD_DATA_IN[7:4].
//
// state | meaning
// IDLE  | waiting for a rising edge on iStart
// SETUP | RS/RW stable, EN low (address setup)
// EN_HI | EN high; bus sampled on the last cycle
// EN_LO | EN low hold; next nibble, next poll or finish
// DONE  | RW released, oDone set; back to IDLE
module lcd_read_controller
   import lcd_pkg::*;
#(
   parameter int SETUP_CLKS   = LCD_SETUP_CLKS,
   parameter int EN_HIGH_CLKS = LCD_EN_HIGH_CLKS,
   parameter int EN_LOW_CLKS  = LCD_EN_LOW_CLKS,
   parameter int POLL_MAX     = LCD_POLL_MAX
) (
   input logic                  iCLK,
   input logic                  iRST,
   lcd_read_controller_if.slave bus
);
   localparam int TW = LCD_TMR_W;

   if (SETUP_CLKS < 1 || EN_HIGH_CLKS < 1 || EN_LOW_CLKS < 1) begin : g_bad_clks
      $error("lcd_read_controller: every phase length must be at least 1");
   end
   if (POLL_MAX < 0 || POLL_MAX > 1023) begin : g_bad_poll
      $error("lcd_read_controller: POLL_MAX must fit the 10-bit attempt counter");
   end

   lcd_state_t    state;
   logic          start_prev;
   logic          rs_q;
   logic          poll_q;
   logic [9:0]    attempts;
   logic [7:0]    data_q;
   logic          done_q;
   logic          timeout_q;
   logic          bus_own;
   logic          en_q;
   logic          start_acc;
   logic          again_busy;
   logic          nib_more;
   logic          tmr_load;
   logic [TW-1:0] tmr_val;
   logic          tmr_tc;
`ifdef LCD_4BIT_EN
   logic          nibble;
   assign nib_more = ~nibble;
`else
   assign nib_more = 1'b0;
`endif

   assign start_acc  = bus.iStart && !start_prev && (state == IDLE);
   assign again_busy = poll_q && data_q[LCD_BF_BIT] && (attempts < 10'(POLL_MAX));

   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state)
         IDLE:  if (start_acc) begin tmr_load = 1'b1; tmr_val = TW'(SETUP_CLKS - 1); end
         SETUP: if (tmr_tc) begin tmr_load = 1'b1; tmr_val = TW'(EN_HIGH_CLKS - 1); end
         EN_HI: if (tmr_tc) begin tmr_load = 1'b1; tmr_val = TW'(EN_LOW_CLKS - 1); end
         EN_LO: if (tmr_tc && (nib_more || again_busy)) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(EN_HIGH_CLKS - 1);
         end
         default: ;
      endcase
   end

   lcd_phase_timer #(.W(TW)) u_timer (
      .iCLK     (iCLK),
      .iRST     (iRST),
      .load     (tmr_load),
      .load_val (tmr_val),
      .tc       (tmr_tc)
   );

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state      <= IDLE;
         start_prev <= 1'b0;
         rs_q       <= 1'b0;
         poll_q     <= 1'b0;
         attempts   <= '0;
         data_q     <= '0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
         bus_own    <= 1'b0;
         en_q       <= 1'b0;
`ifdef LCD_4BIT_EN
         nibble     <= 1'b0;
`endif
      end else begin
         start_prev <= bus.iStart;
         case (state)
            IDLE: if (start_acc) begin
               state     <= SETUP;
               done_q    <= 1'b0;
               timeout_q <= 1'b0;
               rs_q      <= bus.iPoll ? LCD_RS_INSTR : bus.iRS;
               poll_q    <= bus.iPoll;
               attempts  <= '0;
               bus_own   <= 1'b1;
`ifdef LCD_4BIT_EN
               nibble    <= 1'b0;
`endif
            end
            SETUP: if (tmr_tc) begin
               state <= EN_HI;
               en_q  <= 1'b1;
            end
            EN_HI: if (tmr_tc) begin
               state <= EN_LO;
               en_q  <= 1'b0;
`ifdef LCD_4BIT_EN
               if (!nibble) data_q[7:4] <= bus.LCD_DATA_IN[7:4];
               else         data_q[3:0] <= bus.LCD_DATA_IN[7:4];
`else
               data_q <= bus.LCD_DATA_IN;
`endif
            end
            EN_LO: if (tmr_tc) begin
               if (nib_more) begin
`ifdef LCD_4BIT_EN
                  nibble <= 1'b1;
`endif
                  state <= EN_HI;
                  en_q  <= 1'b1;
               end else if (again_busy) begin
`ifdef LCD_4BIT_EN
                  nibble <= 1'b0;
`endif
                  attempts <= attempts + 1'b1;
                  state    <= EN_HI;
                  en_q     <= 1'b1;
               end else begin
                  // Still busy here in poll mode can only mean the attempt budget ran out.
                  state     <= DONE;
                  bus_own   <= 1'b0;
                  done_q    <= 1'b1;
                  timeout_q <= poll_q && data_q[LCD_BF_BIT];
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.oDATA    = data_q;
   assign bus.oDone    = done_q;
   assign bus.oTimeout = timeout_q;
   assign bus.oBusOwn  = bus_own;
   assign bus.LCD_RW   = bus_own;
   assign bus.LCD_RS   = rs_q;
   assign bus.LCD_EN   = en_q;
endmodule

// File: tb/tb_lcd_read_controller.sv
// Self-checking bench for lcd_read_controller: vector table, random poll/read traffic
// against a per-read reference model, and hand sequences for start/reset corner cases.
module tb_lcd_read_controller;
   localparam int S  = 2;
   localparam int H  = 16;
   localparam int L  = 16;
   localparam int PM = 4;
`ifdef LCD_4BIT_EN
   localparam int NIB = 2;
`else
   localparam int NIB = 1;
`endif

   typedef logic [0:7][7:0] bytes_t;
   typedef struct {
      logic       rs;
      logic       poll;
      bytes_t     bytes;
      logic [7:0] exp_data;
      logic       exp_to;
      int         exp_reads;
   } vec_t;

   logic iCLK = 1'b0;
   logic iRST;
   always #5 iCLK = ~iCLK;

   lcd_read_controller_if bus_if ();

   lcd_read_controller #(
      .SETUP_CLKS   (S),
      .EN_HIGH_CLKS (H),
      .EN_LOW_CLKS  (L),
      .POLL_MAX     (PM)
   ) dut (
      .iCLK (iCLK),
      .iRST (iRST),
      .bus  (bus_if)
   );

   int checks = 0;
   int errors = 0;

   int         pulse_tot = 0;
   int         rw_rise_tot = 0;
   int         viol_tot = 0;
   int         resp_base = 0;
   logic [7:0] resp [16];

   // LCD model: presents resp[n] during the n-th EN pulse of the current transfer.
   initial begin
      logic en_p, rw_p, rs_p;
      int   idx;
      en_p = 1'b0; rw_p = 1'b0; rs_p = 1'b0;
      bus_if.LCD_DATA_IN = 8'h00;
      forever begin
         @(negedge iCLK);
         if (bus_if.LCD_EN && !en_p) pulse_tot++;
         if (bus_if.LCD_RW && !rw_p) rw_rise_tot++;
         if ((bus_if.LCD_RS !== rs_p || bus_if.LCD_RW !== rw_p) && (bus_if.LCD_EN || en_p))
            viol_tot++;
         en_p = bus_if.LCD_EN; rw_p = bus_if.LCD_RW; rs_p = bus_if.LCD_RS;
         idx = pulse_tot - resp_base - 1;
         if (idx < 0) idx = 0;
         if (idx > 15) idx = 15;
         bus_if.LCD_DATA_IN = resp[idx];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic load_resp(input bytes_t b);
      for (int k = 0; k < 16; k++) resp[k] = 8'hFF;
      for (int k = 0; k < 8; k++) begin
         if (NIB == 1) resp[k] = b[k];
         else begin
            resp[2*k]   = {b[k][7:4], 4'($urandom)};
            resp[2*k+1] = {b[k][3:0], 4'($urandom)};
         end
      end
   endtask

   // Reference: walk the reads the LCD would answer until BF clears or the budget is spent.
   task automatic model(input bytes_t b, input logic poll,
                        output logic [7:0] d, output logic to, output int reads);
      d = b[0]; to = 1'b0; reads = 1;
      if (poll) begin
         for (int r = 0; r < 8; r++) begin
            d = b[r];
            reads = r + 1;
            if (!d[7]) break;
            if (r == PM) begin to = 1'b1; break; end
         end
      end
   endtask

   task automatic wait_done(output int lat, input logic timing);
      lat = 1;
      while (!bus_if.oDone && lat < 3000) begin
         @(negedge iCLK);
         lat++;
         if (timing) begin
            if (lat == 2)  chk("en_low_t2", 32'(bus_if.LCD_EN), 32'd0);
            if (lat == 3)  chk("en_high_t3", 32'(bus_if.LCD_EN), 32'd1);
            if (lat == 18) chk("en_high_t18", 32'(bus_if.LCD_EN), 32'd1);
            if (lat == 19) chk("en_low_t19", 32'(bus_if.LCD_EN), 32'd0);
         end
      end
   endtask

   task automatic run_txn(input string name, input logic rs, input logic poll, input bytes_t b,
                          input logic [7:0] exp_d, input logic exp_to, input int exp_reads,
                          input logic timing);
      int p0, r0, v0, lat;
      load_resp(b);
      @(negedge iCLK);
      p0 = pulse_tot; r0 = rw_rise_tot; v0 = viol_tot;
      resp_base = pulse_tot;
      bus_if.iRS = rs; bus_if.iPoll = poll; bus_if.iStart = 1'b1;
      @(posedge iCLK);
      @(negedge iCLK);
      chk({name, "_done_cleared"}, 32'(bus_if.oDone), 32'd0);
      chk({name, "_rw_t1"}, 32'(bus_if.LCD_RW), 32'd1);
      wait_done(lat, timing);
      chk({name, "_latency"}, 32'(lat), 32'(1 + S + exp_reads * NIB * (H + L)));
      chk({name, "_data"}, 32'(bus_if.oDATA), 32'(exp_d));
      chk({name, "_timeout"}, 32'(bus_if.oTimeout), 32'(exp_to));
      chk({name, "_rs"}, 32'(bus_if.LCD_RS), 32'(poll ? 1'b0 : rs));
      chk({name, "_rw_done"}, 32'(bus_if.LCD_RW), 32'd0);
      chk({name, "_pulses"}, 32'(pulse_tot - p0), 32'(exp_reads * NIB));
      chk({name, "_setup_once"}, 32'(rw_rise_tot - r0), 32'd1);
      chk({name, "_rs_rw_stable"}, 32'(viol_tot - v0), 32'd0);
      bus_if.iStart = 1'b0;
      @(negedge iCLK);
      @(negedge iCLK);
      chk({name, "_done_held"}, 32'(bus_if.oDone), 32'd1);
   endtask

   vec_t vecs [5];

   initial begin
      int         p0, lat;
      bytes_t     b;
      logic [7:0] d;
      logic       to, rs, poll;
      int         reads, k;

      vecs[0] = '{rs: 1'b1, poll: 1'b0, bytes: {8'hA5, 56'h0},
                  exp_data: 8'hA5, exp_to: 1'b0, exp_reads: 1};
      vecs[1] = '{rs: 1'b0, poll: 1'b0, bytes: {8'h8F, 56'h0},
                  exp_data: 8'h8F, exp_to: 1'b0, exp_reads: 1};
      vecs[2] = '{rs: 1'b0, poll: 1'b1, bytes: {8'h80, 8'h81, 8'h82, 8'h0C, 32'h0},
                  exp_data: 8'h0C, exp_to: 1'b0, exp_reads: 4};
      vecs[3] = '{rs: 1'b1, poll: 1'b1,
                  bytes: {8'h9A, 8'h9B, 8'h9C, 8'h9D, 8'h9E, 8'h9F, 16'h0},
                  exp_data: 8'h9E, exp_to: 1'b1, exp_reads: 5};
      vecs[4] = '{rs: 1'b1, poll: 1'b1, bytes: {8'h05, 56'h0},
                  exp_data: 8'h05, exp_to: 1'b0, exp_reads: 1};

      for (int i = 0; i < 16; i++) resp[i] = 8'hFF;
      iRST = 1'b1;
      bus_if.iStart = 1'b0; bus_if.iRS = 1'b0; bus_if.iPoll = 1'b0;
      repeat (3) @(posedge iCLK);
      @(negedge iCLK);
      chk("rst_done", 32'(bus_if.oDone), 32'd0);
      chk("rst_timeout", 32'(bus_if.oTimeout), 32'd0);
      chk("rst_data", 32'(bus_if.oDATA), 32'd0);
      chk("rst_en", 32'(bus_if.LCD_EN), 32'd0);
      chk("rst_rw", 32'(bus_if.LCD_RW), 32'd0);
      chk("rst_busown", 32'(bus_if.oBusOwn), 32'd0);
      chk("rst_rs", 32'(bus_if.LCD_RS), 32'd0);
      iRST = 1'b0;
      @(negedge iCLK);

      for (int i = 0; i < 5; i++)
         run_txn($sformatf("vec%0d", i), vecs[i].rs, vecs[i].poll, vecs[i].bytes,
                 vecs[i].exp_data, vecs[i].exp_to, vecs[i].exp_reads, i == 0);

      for (int i = 0; i < 30; i++) begin
         rs   = 1'($urandom);
         poll = 1'($urandom);
         b    = '0;
         if (poll) begin
            k = int'($urandom_range(0, 6));
            for (int j = 0; j < k; j++) b[j] = 8'($urandom) | 8'h80;
            b[k] = 8'($urandom) & 8'h7F;
         end else begin
            b[0] = 8'($urandom);
         end
         model(b, poll, d, to, reads);
         run_txn($sformatf("rnd%0d", i), rs, poll, b, d, to, reads, 1'b0);
      end

      // Held start plus an extra rising edge during EN_HI: exactly one transfer.
      load_resp({8'h5A, 56'h0});
      @(negedge iCLK);
      p0 = pulse_tot;
      resp_base = pulse_tot;
      bus_if.iRS = 1'b1; bus_if.iPoll = 1'b0; bus_if.iStart = 1'b1;
      @(posedge iCLK);
      repeat (5) @(negedge iCLK);
      bus_if.iStart = 1'b0;
      @(negedge iCLK);
      bus_if.iStart = 1'b1;
      wait_done(lat, 1'b0);
      chk("held_latency", 32'(lat), 32'(1 + S + NIB * (H + L) - 5));
      repeat (60) @(negedge iCLK);
      chk("held_one_xfer", 32'(pulse_tot - p0), 32'(NIB));
      chk("held_done", 32'(bus_if.oDone), 32'd1);
      chk("held_data", 32'(bus_if.oDATA), 32'h5A);
      bus_if.iStart = 1'b0;
      @(negedge iCLK);
      resp_base = pulse_tot;
      bus_if.iStart = 1'b1;
      @(posedge iCLK);
      @(negedge iCLK);
      chk("retrigger_accepted", 32'(bus_if.oDone), 32'd0);
      wait_done(lat, 1'b0);
      chk("retrigger_pulses", 32'(pulse_tot - p0), 32'(2 * NIB));
      bus_if.iStart = 1'b0;
      repeat (2) @(negedge iCLK);

      // Reset in the middle of EN high.
      load_resp({8'h3C, 56'h0});
      resp_base = pulse_tot;
      bus_if.iRS = 1'b1; bus_if.iStart = 1'b1;
      @(posedge iCLK);
      repeat (6) @(negedge iCLK);
      chk("pre_rst_en", 32'(bus_if.LCD_EN), 32'd1);
      iRST = 1'b1;
      bus_if.iStart = 1'b0;
      @(posedge iCLK);
      @(negedge iCLK);
      chk("midrst_en", 32'(bus_if.LCD_EN), 32'd0);
      chk("midrst_rw", 32'(bus_if.LCD_RW), 32'd0);
      chk("midrst_done", 32'(bus_if.oDone), 32'd0);
      chk("midrst_data", 32'(bus_if.oDATA), 32'd0);
      iRST = 1'b0;
      repeat (40) @(negedge iCLK);
      chk("midrst_no_done", 32'(bus_if.oDone), 32'd0);
      run_txn("post_rst", 1'b1, 1'b0, {8'h3C, 56'h0}, 8'h3C, 1'b0, 1, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
